// File: rtl/bus_memory_pkg.sv
// Shared definitions for the bus memory and the CPU datapath: default
// geometry and the loader/run state encoding.
package bus_memory_pkg;

    localparam int unsigned DefDepth = 64;
    localparam int unsigned DefAdrW  = 6;
    localparam int unsigned DefDataW = 8;

    typedef enum logic {
        StLoad = 1'b0,
        StRun  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_loader.sv
// Boot loader sequencer: accepts loader words into consecutive addresses, holds
// the CPU while loading, then hands over to RUN until the next reset.
module mem_loader
    import bus_memory_pkg::*;
#(
    parameter int unsigned DEPTH         = DefDepth,
    parameter int unsigned ADR_W         = DefAdrW,
    parameter bit          LOAD_ON_RESET = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ld_valid_i,
    input  logic             ld_last_i,
    output logic             ld_ready_o,
    output logic             cpu_hold_o,
    output logic             ld_we_o,
    output logic [ADR_W-1:0] ld_ptr_o,
    output mem_state_e       state_o
);

    mem_state_e       state_q, state_d;
    logic [ADR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic             ld_we;

    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        ld_we    = 1'b0;
        if (state_q == StLoad && ld_valid_i) begin
            ld_we    = 1'b1;
            ld_ptr_d = ld_ptr_q + ADR_W'(1);
            // Leaving LOAD on the last slot keeps the wrapped pointer from writing.
            if (ld_last_i || ld_ptr_q == ADR_W'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= LOAD_ON_RESET ? StLoad : StRun;
            ld_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            ld_ptr_q <= ld_ptr_d;
        end
    end

    // Reset forces the post-reset view immediately and blocks the write.
    assign ld_ready_o = reset_i ? LOAD_ON_RESET : (state_q == StLoad);
    assign cpu_hold_o = ld_ready_o;
    assign ld_we_o    = ld_we & ~reset_i;
    assign ld_ptr_o   = ld_ptr_q;
    assign state_o    = state_q;

endmodule

// File: rtl/bus_memory.sv
// Word memory on a shared bidirectional CPU bus, preloaded through a simple
// valid/ready loader port before the CPU is released.
module bus_memory
    import bus_memory_pkg::*;
#(
    parameter int unsigned DEPTH         = DefDepth,
    parameter int unsigned ADR_W         = DefAdrW,
    parameter int unsigned DATA_W        = DefDataW,
    parameter bit          LOAD_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr_bus,
    input  logic              rd_mem,
    input  logic              wr_mem,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              bus_err
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              bus_err_q;
    logic              ld_we;
    logic [ADR_W-1:0]  ld_ptr;
    mem_state_e        state;
    logic              run;
    logic              cpu_we;
    logic              rd_drive;

    mem_loader #(
        .DEPTH        (DEPTH),
        .ADR_W        (ADR_W),
        .LOAD_ON_RESET(LOAD_ON_RESET)
    ) u_loader (
        .clk_i     (clk),
        .reset_i   (reset),
        .ld_valid_i(ld_valid),
        .ld_last_i (ld_last),
        .ld_ready_o(ld_ready),
        .cpu_hold_o(cpu_hold),
        .ld_we_o   (ld_we),
        .ld_ptr_o  (ld_ptr),
        .state_o   (state)
    );

    assign run      = (state == StRun) & ~reset;
    assign cpu_we   = run & wr_mem & ~rd_mem;
    assign rd_drive = run & rd_mem & ~wr_mem;

    // Array is deliberately left out of reset so a reload keeps old contents.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ld_ptr] <= ld_data;
        end else if (cpu_we) begin
            mem_q[adr_bus] <= data_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else if (run && rd_mem && wr_mem) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err  = bus_err_q & ~reset;
    assign data_bus = rd_drive ? mem_q[adr_bus] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_bus_memory.sv
// Directed bench for bus_memory: loader handshake, CPU bus reads/writes,
// collisions, mid-load reset, and the LOAD_ON_RESET=0 variant.
module tb_bus_memory;

    logic       clk = 1'b0;
    logic       reset;
    int         n_checks = 0;
    int         n_errors = 0;

    // Instance 1: LOAD_ON_RESET = 1
    logic [5:0] adr_bus;
    logic       rd_mem, wr_mem;
    wire  [7:0] data_bus;
    logic       tb_oe;
    logic [7:0] tb_dat;
    logic       ld_valid, ld_last;
    logic [7:0] ld_data;
    logic       ld_ready, cpu_hold, bus_err;

    // Instance 2: LOAD_ON_RESET = 0
    logic [5:0] adr_bus2;
    logic       rd_mem2, wr_mem2;
    wire  [7:0] data_bus2;
    logic       tb_oe2;
    logic [7:0] tb_dat2;
    logic       ld_valid2, ld_last2;
    logic [7:0] ld_data2;
    logic       ld_ready2, cpu_hold2, bus_err2;

    assign data_bus  = tb_oe  ? tb_dat  : 8'hzz;
    assign data_bus2 = tb_oe2 ? tb_dat2 : 8'hzz;

    always #5 clk = ~clk;

    bus_memory #(
        .DEPTH(64), .ADR_W(6), .DATA_W(8), .LOAD_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .adr_bus(adr_bus), .rd_mem(rd_mem), .wr_mem(wr_mem),
        .data_bus(data_bus), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .cpu_hold(cpu_hold), .bus_err(bus_err)
    );

    bus_memory #(
        .DEPTH(64), .ADR_W(6), .DATA_W(8), .LOAD_ON_RESET(1'b0)
    ) dut2 (
        .clk(clk), .reset(reset), .adr_bus(adr_bus2), .rd_mem(rd_mem2), .wr_mem(wr_mem2),
        .data_bus(data_bus2), .ld_valid(ld_valid2), .ld_data(ld_data2), .ld_last(ld_last2),
        .ld_ready(ld_ready2), .cpu_hold(cpu_hold2), .bus_err(bus_err2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // The bench drives 0x00 whenever it is idle; a DUT drive of nonzero data shows up.
    task automatic idle_bus();
        rd_mem = 1'b0;
        wr_mem = 1'b0;
        tb_oe  = 1'b1;
        tb_dat = 8'h00;
    endtask

    task automatic load_word(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] adr, input logic [7:0] exp);
        tb_oe   = 1'b0;
        rd_mem  = 1'b1;
        adr_bus = adr;
        #1 check_eq(tag, {24'h0, data_bus}, {24'h0, exp});
        @(negedge clk);
        idle_bus();
    endtask

    task automatic cpu_wr(input logic [5:0] adr, input logic [7:0] d);
        tb_oe   = 1'b1;
        tb_dat  = d;
        wr_mem  = 1'b1;
        adr_bus = adr;
        @(negedge clk);
        idle_bus();
    endtask

    initial begin
        reset     = 1'b1;
        adr_bus   = '0;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        ld_data   = '0;
        idle_bus();
        adr_bus2  = '0;
        rd_mem2   = 1'b0;
        wr_mem2   = 1'b0;
        tb_oe2    = 1'b1;
        tb_dat2   = 8'h00;
        ld_valid2 = 1'b0;
        ld_last2  = 1'b0;
        ld_data2  = '0;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_ld_ready", {31'h0, ld_ready}, 32'd1);
        check_eq("rst_cpu_hold", {31'h0, cpu_hold}, 32'd1);
        check_eq("rst_bus_err", {31'h0, bus_err}, 32'd0);
        check_eq("rst_bus_hiz", {24'h0, data_bus}, 32'h00);
        check_eq("rst2_ld_ready", {31'h0, ld_ready2}, 32'd0);
        check_eq("rst2_cpu_hold", {31'h0, cpu_hold2}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Three-word load ending on ld_last
        load_word(8'h11, 1'b0);
        load_word(8'h22, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 8'h33;
        ld_last  = 1'b1;
        #1 check_eq("ld3_ready_before", {31'h0, ld_ready}, 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        #1;
        check_eq("ld3_ready_after", {31'h0, ld_ready}, 32'd0);
        check_eq("ld3_hold_after", {31'h0, cpu_hold}, 32'd0);
        rd_chk("ld3_rd0", 6'd0, 8'h11);
        rd_chk("ld3_rd1", 6'd1, 8'h22);
        rd_chk("ld3_rd2", 6'd2, 8'h33);

        // Full 64-word load, then a 65th word that must be ignored
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'(i);
            if (i == 63) #1 check_eq("ld64_ready_last", {31'h0, ld_ready}, 32'd1);
            @(negedge clk);
        end
        ld_data = 8'hEE;
        #1;
        check_eq("ld64_ready_done", {31'h0, ld_ready}, 32'd0);
        check_eq("ld64_hold_done", {31'h0, cpu_hold}, 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        rd_chk("ld64_rd0", 6'd0, 8'h00);
        rd_chk("ld64_rd1", 6'd1, 8'h01);
        rd_chk("ld64_rd63", 6'd63, 8'h3F);

        // CPU write then read-back, then idle bus
        cpu_wr(6'h2A, 8'hC5);
        rd_chk("wr_rd_2a", 6'h2A, 8'hC5);
        adr_bus = 6'h2A;
        #1 check_eq("idle_hiz", {24'h0, data_bus}, 32'h00);
        @(negedge clk);

        // Read/write collision
        rd_mem  = 1'b1;
        wr_mem  = 1'b1;
        adr_bus = 6'h05;
        tb_dat  = 8'h77;
        #1;
        check_eq("col_bus_77", {24'h0, data_bus}, 32'h77);
        check_eq("col_err_pre", {31'h0, bus_err}, 32'd0);
        @(negedge clk);
        tb_dat = 8'h00;
        #1;
        check_eq("col_bus_00", {24'h0, data_bus}, 32'h00);
        check_eq("col_err_set", {31'h0, bus_err}, 32'd1);
        @(negedge clk);
        idle_bus();
        rd_chk("col_mem5", 6'h05, 8'h05);
        @(negedge clk);
        #1 check_eq("col_err_sticky", {31'h0, bus_err}, 32'd1);

        // Reset in the middle of a four-word load
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_eq("mid_rst_ready", {31'h0, ld_ready}, 32'd1);
        check_eq("mid_rst_hold", {31'h0, cpu_hold}, 32'd1);
        check_eq("mid_rst_err", {31'h0, bus_err}, 32'd0);
        reset = 1'b0;
        load_word(8'h51, 1'b0);
        load_word(8'h52, 1'b0);
        rd_mem   = 1'b1;
        adr_bus  = 6'd3;
        ld_valid = 1'b1;
        ld_data  = 8'h53;
        reset    = 1'b1;
        #1 check_eq("load_rd_hiz", {24'h0, data_bus}, 32'h00);
        @(negedge clk);
        reset    = 1'b0;
        ld_valid = 1'b0;
        idle_bus();
        load_word(8'hAA, 1'b1);
        #1 check_eq("reload_run", {31'h0, cpu_hold}, 32'd0);
        rd_chk("reload_rd0", 6'd0, 8'hAA);
        rd_chk("reload_rd1", 6'd1, 8'h52);
        rd_chk("reload_rd2", 6'd2, 8'h02);

        // LOAD_ON_RESET = 0 instance ignores the loader
        tb_oe2   = 1'b1;
        tb_dat2  = 8'h12;
        wr_mem2  = 1'b1;
        adr_bus2 = 6'd0;
        @(negedge clk);
        wr_mem2   = 1'b0;
        tb_dat2   = 8'h00;
        ld_valid2 = 1'b1;
        ld_data2  = 8'hFF;
        #1 check_eq("nl_ld_ready", {31'h0, ld_ready2}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        ld_valid2 = 1'b0;
        tb_oe2    = 1'b0;
        rd_mem2   = 1'b1;
        #1 check_eq("nl_rd0", {24'h0, data_bus2}, 32'h12);
        check_eq("nl_hold", {31'h0, cpu_hold2}, 32'd0);
        @(negedge clk);
        rd_mem2 = 1'b0;
        tb_oe2  = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
